// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative signed multiplier.
package mul_pkg;

    localparam int unsigned DefWidth    = 16;
    localparam int unsigned DefOutWidth = 32;

    // ALU opcode that selects the multiplier.
    localparam logic [3:0] OP_MUL = 4'd2;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

endpackage

// File: rtl/mul_sign_mag.sv
// Combinational conditional negate: yields |x| for operand capture (negate on sign bit)
// and applies the product sign to the accumulator on completion.
module mul_sign_mag #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] value_i,
    input  logic         negate_i,
    output logic [W-1:0] mag_o
);

    always_comb begin
        mag_o = negate_i ? (~value_i + W'(1)) : value_i;
    end

endmodule

// File: rtl/seq_multiply.sv
// Iterative sign-magnitude shift-add signed multiplier, one multiplier bit per cycle.
// Optional SEQ_MULTIPLY_ZERO_BYPASS_EN: zero operands finish one cycle after capture.
module seq_multiply
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned OUT_WIDTH = DefOutWidth
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [OUT_WIDTH-1:0] product,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned AccW = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [AccW-1:0]        acc_q, acc_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   neg_q, neg_d;
    logic [OUT_WIDTH-1:0]   product_q, product_d;
    logic                   error_q, error_d;

    logic [WIDTH-1:0]       abs_a, abs_b;
    logic [AccW-1:0]        res;
    logic [AccW-OUT_WIDTH:0] res_hi;
    logic                   ovf;
    logic                   capture;
    logic                   finish;

    mul_sign_mag #(.W(WIDTH)) u_abs_a (
        .value_i  (multiplicand),
        .negate_i (multiplicand[WIDTH-1]),
        .mag_o    (abs_a)
    );

    mul_sign_mag #(.W(WIDTH)) u_abs_b (
        .value_i  (multiplier),
        .negate_i (multiplier[WIDTH-1]),
        .mag_o    (abs_b)
    );

    mul_sign_mag #(.W(AccW)) u_result (
        .value_i  (acc_q),
        .negate_i (neg_q),
        .mag_o    (res)
    );

    // Representable iff every bit from OUT_WIDTH-1 upward matches the sign.
    always_comb begin
        res_hi = res[AccW-1:OUT_WIDTH-1];
        ovf    = !((&res_hi) || !(|res_hi));
    end

`ifdef SEQ_MULTIPLY_ZERO_BYPASS_EN
    logic zero_q, zero_d;

    always_comb begin
        zero_d = zero_q;
        if (capture) begin
            zero_d = (abs_a == '0) || (abs_b == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign finish = (cnt_q == CntW'(WIDTH)) || zero_q;
`else
    assign finish = (cnt_q == CntW'(WIDTH));
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        error_d   = error_q;
        capture   = 1'b0;

        unique case (state_q)
            StIdle: begin
                capture = start;
            end
            StCalc: begin
                if (finish) begin
                    state_d   = StDone;
                    product_d = res[OUT_WIDTH-1:0];
                    error_d   = ovf;
                end else begin
                    if (b_q[0]) begin
                        acc_d = acc_q + (AccW'(a_q) << cnt_q);
                    end
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                capture = start;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (capture) begin
            state_d = StCalc;
            a_d     = abs_a;
            b_d     = abs_b;
            neg_d   = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            error_q   <= error_d;
        end
    end

    assign product = product_q;
    assign error   = error_q;
    assign busy    = (state_q == StCalc);
    assign done    = (state_q == StDone);

endmodule

// File: tb/tb_seq_multiply.sv
// Directed bench for seq_multiply: a 16x16->32 instance and a 16x16->16 instance.
module tb_seq_multiply;

    logic        clk;
    logic        rst_n;
    logic        start,   start16;
    logic [15:0] mcand,   mcand16;
    logic [15:0] mplier,  mplier16;
    logic [31:0] prod32;
    logic [15:0] prod16;
    logic        busy32,  busy16;
    logic        done32,  done16;
    logic        err32,   err16;

    int tests = 0;
    int fails = 0;

`ifdef SEQ_MULTIPLY_ZERO_BYPASS_EN
    localparam int ZeroLat = 1;
`else
    localparam int ZeroLat = 17;
`endif

    seq_multiply #(.WIDTH(16), .OUT_WIDTH(32)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .product      (prod32),
        .busy         (busy32),
        .done         (done32),
        .error        (err32)
    );

    seq_multiply #(.WIDTH(16), .OUT_WIDTH(16)) u_dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start16),
        .multiplicand (mcand16),
        .multiplier   (mplier16),
        .product      (prod16),
        .busy         (busy16),
        .done         (done16),
        .error        (err16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one job, wait (bounded) for done, check latency, result and the done pulse width.
    task automatic run_job(input bit sel, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp_p, input logic exp_e, input int exp_lat,
                           input string tag);
        int lat;
        logic d;
        if (sel) begin
            start16 = 1'b1; mcand16 = a; mplier16 = b;
        end else begin
            start = 1'b1; mcand = a; mplier = b;
        end
        tick();
        start   = 1'b0;
        start16 = 1'b0;
        lat = 0;
        d   = 1'b0;
        while (!d && lat < 40) begin
            tick();
            lat++;
            d = sel ? done16 : done32;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_product"}, sel ? {16'h0, prod16} : prod32, exp_p);
        check({tag, "_error"}, {31'h0, sel ? err16 : err32}, {31'h0, exp_e});
        tick();
        check({tag, "_done_drop"}, {31'h0, sel ? done16 : done32}, 32'h0);
    endtask

    initial begin
        int d1, d2, ndone;
        logic [31:0] p2;

        rst_n = 1'b0;
        start = 1'b0; mcand = '0; mplier = '0;
        start16 = 1'b0; mcand16 = '0; mplier16 = '0;
        #12;
        check("reset_product", prod32, 32'h0);
        check("reset_busy", {31'h0, busy32}, 32'h0);
        check("reset_done", {31'h0, done32}, 32'h0);
        check("reset_error", {31'h0, err32}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // 11 * 15 with a cycle-by-cycle busy/done trace.
        start = 1'b1; mcand = 16'd11; mplier = 16'd15;
        tick();
        start = 1'b0;
        for (int e = 0; e <= 16; e++) begin
            check($sformatf("trace_busy_e%0d", e), {31'h0, busy32}, 32'h1);
            check($sformatf("trace_done_e%0d", e), {31'h0, done32}, 32'h0);
            tick();
        end
        check("trace_done_e17", {31'h0, done32}, 32'h1);
        check("trace_busy_e17", {31'h0, busy32}, 32'h0);
        check("trace_product", prod32, 32'd165);
        check("trace_error", {31'h0, err32}, 32'h0);
        tick();
        check("trace_done_e18", {31'h0, done32}, 32'h0);
        check("trace_hold_product", prod32, 32'd165);

        run_job(1'b0, 16'd32000, 16'd16000, 32'h1E848000, 1'b0, 17, "big");
        run_job(1'b0, 16'hFFF9,  16'd6,     32'hFFFFFFD6, 1'b0, 17, "neg7x6");
        run_job(1'b0, 16'h8000,  16'h8000,  32'h40000000, 1'b0, 17, "min_min");
        run_job(1'b0, 16'h8000,  16'h7FFF,  32'hC0008000, 1'b0, 17, "min_max");
        run_job(1'b0, 16'h7FFF,  16'h0000,  32'h0,        1'b0, ZeroLat, "max_zero");
`ifdef SEQ_MULTIPLY_ZERO_BYPASS_EN
        run_job(1'b0, 16'h0000,  16'd1234,  32'h0,        1'b0, 1, "bypass_zero");
`endif

        // Restart while busy is ignored; the new operands are never captured.
        start = 1'b1; mcand = 16'd3; mplier = 16'd5;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; mcand = 16'd9; mplier = 16'd9;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int e = 6; e <= 17; e++) begin
            tick();
            if (done32) begin
                check("ignore_done_edge", 32'(e), 32'd17);
                ndone++;
            end
        end
        check("ignore_done_count", 32'(ndone), 32'd1);
        check("ignore_product", prod32, 32'd15);
        tick();

        // Reset mid-operation aborts the job with no done pulse.
        start = 1'b1; mcand = 16'd100; mplier = 16'd100;
        tick();
        start = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check("abort_product", prod32, 32'h0);
        check("abort_busy", {31'h0, busy32}, 32'h0);
        check("abort_done", {31'h0, done32}, 32'h0);
        check("abort_error", {31'h0, err32}, 32'h0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int e = 0; e < 25; e++) begin
            tick();
            if (done32 || busy32) ndone++;
        end
        check("abort_no_activity", 32'(ndone), 32'h0);
        run_job(1'b0, 16'd2, 16'd2, 32'd4, 1'b0, 17, "after_abort");

        // Back-to-back: start held across DONE so the second job is accepted there.
        start = 1'b1; mcand = 16'd5; mplier = 16'd7;
        tick();
        d1 = -1; d2 = -1; p2 = '0;
        for (int e = 1; e <= 40; e++) begin
            if (e == 20) start = 1'b0;
            tick();
            if (done32) begin
                if (d1 < 0) begin
                    d1 = e;
                end else if (d2 < 0) begin
                    d2 = e;
                    p2 = prod32;
                end
            end
        end
        check("b2b_first_done", 32'(d1), 32'd17);
        check("b2b_second_done", 32'(d2), 32'd35);
        check("b2b_second_product", p2, 32'd35);

        // Narrow output instance.
        run_job(1'b1, 16'd300,  16'd300, 32'h5F90, 1'b1, 17, "n16_300sq");
        run_job(1'b1, 16'd100,  16'd100, 32'd10000, 1'b0, 17, "n16_100sq");
        run_job(1'b1, 16'hFF80, 16'd256, 32'h8000, 1'b0, 17, "n16_m128x256");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
